// File: rtl/h2v_arb_pkg.sv
// Shared definitions for the guard-unit arbiter: FSM state encoding and default widths.
package h2v_arb_pkg;

    localparam int DW = 8;
    localparam int IW = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dfd_0.sv
// Compiled guard function f4: purely combinational, 8-bit unsigned operand.
module dfd_0 (
    input  logic [7:0] arg,
    output logic [7:0] result
);

    // The "<0" branch of f4 folds away: the operand compare is unsigned.
    always_comb begin
        if (arg == '0) result = 8'd2;
        else           result = 8'd1;
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational priority scan: first set request at or after `start`, wrapping at NREQ-1.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   start,
    output logic [IW-1:0]   win_idx,
    output logic            any
);

    int unsigned idx;

    always_comb begin
        win_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = start + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any && req[idx[IW-1:0]]) begin
                any     = 1'b1;
                win_idx = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/guard_unit_arbiter.sv
// Shares one dfd_0 instance among NREQ requesters with a valid/ack result return.
// Define GUARD_ARB_FIXED_PRIORITY_EN for fixed lowest-index-wins priority instead of round-robin.
module guard_unit_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = h2v_arb_pkg::DW,
    parameter int IW   = h2v_arb_pkg::IW
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_arg,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    resp_valid,
    output logic [DW-1:0]      resp_data,
    input  logic [NREQ-1:0]    resp_ack,
    output logic               busy
);

    import h2v_arb_pkg::*;

    state_t          state;
    logic [IW-1:0]   grant_q;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   scan_start;
    logic            pick_any;
    logic [DW-1:0]   arg_q;
    logic [7:0]      unit_out;
    logic [NREQ-1:0] grant_hot;

`ifdef GUARD_ARB_FIXED_PRIORITY_EN
    assign scan_start = '0;
`else
    logic [IW-1:0] rr_ptr;
    assign scan_start = rr_ptr;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req     (req_valid),
        .start   (scan_start),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    dfd_0 u_dfd (
        .arg    (8'(arg_q)),
        .result (unit_out)
    );

    always_comb begin
        grant_hot           = '0;
        grant_hot[grant_q]  = 1'b1;
    end

    // Accept pulse is combinational; gated by reset so all outputs read 0 while held in reset.
    always_comb begin
        req_ready = '0;
        if (reset && state == ST_IDLE && pick_any) req_ready[pick_idx] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            arg_q      <= '0;
            grant_q    <= '0;
            resp_data  <= '0;
            resp_valid <= '0;
            busy       <= 1'b0;
`ifndef GUARD_ARB_FIXED_PRIORITY_EN
            rr_ptr     <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        arg_q   <= req_arg[pick_idx*DW +: DW];
                        grant_q <= pick_idx;
                        busy    <= 1'b1;
                        state   <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    resp_data  <= DW'(unit_out);
                    resp_valid <= grant_hot;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ack[grant_q]) begin
                        resp_valid <= '0;
                        busy       <= 1'b0;
                        state      <= ST_IDLE;
`ifndef GUARD_ARB_FIXED_PRIORITY_EN
                        rr_ptr     <= (grant_q == IW'(NREQ-1)) ? '0 : grant_q + 1'b1;
`endif
                    end
                end
                default: begin
                    resp_valid <= '0;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_guard_unit_arbiter.sv
// Scoreboard bench for guard_unit_arbiter: directed scenarios then randomized traffic.
module tb_guard_unit_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int IW   = 2;

    logic               clock;
    logic               reset;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_arg;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    resp_valid;
    logic [DW-1:0]      resp_data;
    logic [NREQ-1:0]    resp_ack;
    logic               busy;

    guard_unit_arbiter #(
        .NREQ (NREQ),
        .DW   (DW),
        .IW   (IW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_arg    (req_arg),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_ack   (resp_ack),
        .busy       (busy)
    );

    typedef struct {
        int         idx;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   acc_count[NREQ];

    // Reference model state
    bit   outstanding = 0;
    int   ptr = 0;
    int   gnt = 0;
    int   acc_cyc = 0;

    // Driver state
    logic [NREQ-1:0] pend;
    logic [7:0]      args[NREQ];
    int              seen[NREQ];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc = cyc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] f4(input logic [7:0] a);
        return (a == 8'd0) ? 8'd2 : 8'd1;
    endfunction

    function automatic int pick(input logic [NREQ-1:0] r, input int start);
        for (int k = 0; k < NREQ; k++)
            if (r[(start + k) % NREQ]) return (start + k) % NREQ;
        return -1;
    endfunction

    // Accept checker / arbitration model
    initial begin : acc_chk
        logic [NREQ-1:0] exp_r;
        int w;
        for (int i = 0; i < NREQ; i++) acc_count[i] = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                outstanding = 0;
                ptr = 0;
                chk("reset_req_ready", 32'(req_ready), 32'd0);
                chk("reset_busy", 32'(busy), 32'd0);
            end else begin
                exp_r = '0;
                w = -1;
                if (!outstanding && req_valid != '0) begin
                    w = pick(req_valid, ptr);
                    exp_r[w] = 1'b1;
                end
                chk("req_ready", 32'(req_ready), 32'(exp_r));
                chk("busy", 32'(busy), 32'(outstanding));
                if (w >= 0) begin
                    q.push_back('{w, f4(req_arg[w*DW +: DW]), cyc});
                    outstanding = 1;
                    gnt = w;
                    acc_cyc = cyc;
                    acc_count[w] = acc_count[w] + 1;
                end else if (outstanding && cyc >= acc_cyc + 2 && resp_ack[gnt]) begin
                    outstanding = 0;
`ifndef GUARD_ARB_FIXED_PRIORITY_EN
                    ptr = (gnt + 1) % NREQ;
`endif
                end
            end
        end
    end

    // Response monitor
    initial begin : resp_mon
        exp_t e;
        logic [NREQ-1:0] ev, hv;
        logic [DW-1:0] hd;
        bit in_resp;
        in_resp = 0;
        hv = '0;
        hd = '0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                chk("reset_resp_valid", 32'(resp_valid), 32'd0);
                chk("reset_resp_data", 32'(resp_data), 32'd0);
                q.delete();
                in_resp = 0;
            end else if (resp_valid != '0) begin
                if (!in_resp) begin
                    if (q.size() == 0) begin
                        chk("unexpected_resp", 32'(resp_valid), 32'd0);
                    end else begin
                        e = q.pop_front();
                        ev = '0;
                        ev[e.idx] = 1'b1;
                        chk("resp_valid", 32'(resp_valid), 32'(ev));
                        chk("resp_data", 32'(resp_data), 32'(e.data));
                        chk("resp_latency", 32'(cyc - e.cyc), 32'd2);
                    end
                    hv = resp_valid;
                    hd = resp_data;
                    in_resp = 1;
                end else begin
                    chk("hold_resp_valid", 32'(resp_valid), 32'(hv));
                    chk("hold_resp_data", 32'(resp_data), 32'(hd));
                end
                if ((resp_ack & resp_valid) != '0) in_resp = 0;
            end else begin
                if (in_resp) begin
                    chk("resp_dropped", 32'(resp_valid), 32'(hv));
                    in_resp = 0;
                end
                if (q.size() > 0 && cyc > q[0].cyc + 2) begin
                    e = q.pop_front();
                    ev = '0;
                    ev[e.idx] = 1'b1;
                    chk("resp_missing", 32'(resp_valid), 32'(ev));
                end
            end
        end
    end

    task automatic drive();
        req_valid = pend;
        for (int i = 0; i < NREQ; i++) req_arg[i*DW +: DW] = args[i];
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (acc_count[i] != seen[i]) begin
                seen[i] = acc_count[i];
                pend[i] = 1'b0;
            end
        end
        drive();
    endtask

    task automatic put(input int i, input logic [7:0] a);
        pend[i] = 1'b1;
        args[i] = a;
        drive();
    endtask

    task automatic wait_accept(input int i);
        for (int n = 0; n < 40 && pend[i]; n++) step();
        if (pend[i]) begin
            chk("accept_timeout", 32'(pend[i]), 32'd0);
            pend[i] = 1'b0;
            drive();
        end
    endtask

    task automatic settle(input int n);
        repeat (n) step();
    endtask

    initial begin : driver
        logic [7:0] p2[3];
        logic [7:0] a3[NREQ];
        p2 = '{8'h05, 8'hFB, 8'hFF};
        a3 = '{8'h00, 8'h01, 8'h00, 8'h02};
        reset = 1'b0;
        pend = '0;
        resp_ack = '0;
        for (int i = 0; i < NREQ; i++) begin
            args[i] = '0;
            seen[i] = 0;
        end
        req_arg = '0;
        drive();
        settle(3);
        reset = 1'b1;
        settle(1);

        // Single request, zero operand, immediate ack
        resp_ack = '1;
        put(0, 8'h00);
        wait_accept(0);
        settle(5);

        // Nonzero operands
        for (int k = 0; k < 3; k++) begin
            put(0, p2[k]);
            wait_accept(0);
            settle(5);
        end

        // All requesters continuously, pointer from 0
        reset = 1'b0;
        step();
        reset = 1'b1;
        for (int i = 0; i < NREQ; i++) put(i, a3[i]);
        repeat (30) begin
            step();
            for (int i = 0; i < NREQ; i++) if (!pend[i]) put(i, a3[i]);
        end
        pend = '0;
        drive();
        settle(6);

        // Delayed ack with a second requester waiting
        resp_ack = '0;
        put(0, 8'h33);
        put(2, 8'h00);
        for (int n = 0; n < 40 && pend[0] && pend[2]; n++) step();
        settle(6);
        resp_ack = '1;
        wait_accept(0);
        wait_accept(2);
        settle(5);

        // Reset during EVAL, then re-request
        put(1, 8'h00);
        wait_accept(1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        settle(4);
        put(1, 8'h00);
        wait_accept(1);
        settle(5);

        // Requesters 1 and 3 held continuously
        repeat (40) begin
            resp_ack = NREQ'($urandom);
            step();
            if (!pend[1]) put(1, 8'($urandom));
            if (!pend[3]) put(3, 8'($urandom));
        end
        pend = '0;
        resp_ack = '1;
        drive();
        settle(6);

        // Randomized traffic with withdrawals, noisy acks and rare resets
        repeat (1500) begin
            for (int i = 0; i < NREQ; i++) begin
                resp_ack[i] = ($urandom_range(0, 2) == 0);
            end
            if ($urandom_range(0, 299) == 0) reset = 1'b0;
            else reset = 1'b1;
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        case ($urandom_range(0, 3))
                            0: put(i, 8'h00);
                            1: put(i, 8'hFF);
                            default: put(i, 8'($urandom));
                        endcase
                    end
                end else if ($urandom_range(0, 49) == 0) begin
                    pend[i] = 1'b0;
                    drive();
                end
            end
        end
        reset = 1'b1;
        pend = '0;
        resp_ack = '1;
        drive();
        settle(8);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=running expected=finished cycle=%0d", cyc);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

endmodule
